csa_final_adder: RTL



---
 rtl/csa_final_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/csa_final_adder.sv
// ---------------------------------------------------------------------------
// csa_final_adder
//   Carry-propagate stage behind the Booth/Wallace compressor tree. It turns
//   the redundant (sum, carry) pair into a binary result. The addition runs
//   serially, one CHUNK-bit slice per clock, with a carry passed between
//   slices. This keeps the full WIDTH-bit ripple out of a single cycle.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   in_valid   : upstream offers sum_in/carry_in
//   in_ready   : operand pair accepted on this edge if in_valid (combinational)
//   sum_in     : redundant sum vector  [WIDTH-1:0]
//   carry_in   : redundant carry vector, already aligned [WIDTH-1:0]
//   out_valid  : result/cout valid
//   out_ready  : downstream takes result
//   result     : (sum_in + carry_in) mod 2^WIDTH
//   cout       : carry out of bit WIDTH-1 (informational)
//   busy       : operation in flight or result waiting (state != IDLE)
// ---------------------------------------------------------------------------
module csa_final_adder #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_sum;
  logic [WIDTH-1:0]   r_carry;
  logic [WIDTH-1:0]   r_result;
  logic [IDX_W-1:0]   r_idx;
  logic               r_c;
  logic               r_cout;
  logic               r_out_valid;

  logic               w_accept;
  logic               w_last;
  logic [CHUNK:0]     w_slice;

  // in_ready already contains !rst, so no accept can happen during reset.
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_idx == IDX_W'(NCHUNK - 1));

  // Slice i adder. The extra top bit is the carry into slice i+1.
  assign w_slice = {1'b0, r_sum[r_idx*CHUNK +: CHUNK]}
                 + {1'b0, r_carry[r_idx*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, r_c};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_ADD;
      S_ADD:  if (w_last)   w_state_nxt = S_DONE;
      S_DONE: begin
        // Consuming the result and accepting new operands can share an edge.
        if (out_ready) w_state_nxt = in_valid ? S_ADD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. in_ready depends combinationally on out_ready in DONE.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (!rst) begin
      in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    end
    busy = (r_state != S_IDLE);
  end

  // Operand latch, slice accumulation and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_carry     <= '0;
      r_result    <= '0;
      r_idx       <= '0;
      r_c         <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_sum       <= sum_in;
      r_carry     <= carry_in;
      r_idx       <= '0;
      r_c         <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (r_state == S_ADD) begin
      r_result[r_idx*CHUNK +: CHUNK] <= w_slice[CHUNK-1:0];
      r_c   <= w_slice[CHUNK];
      r_idx <= r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout      <= w_slice[CHUNK];
        r_out_valid <= 1'b1;
      end
    end else if ((r_state == S_DONE) && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign result    = r_result;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

endmodule
